// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU control codes and datapath mux selects.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, control strobes out.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [1:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic [2:0] alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       illegal_instr;
    logic       mem_err;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output imm_src, alu_src_a, alu_src_b, result_src, adr_src, alu_control,
               ir_write, pc_write, reg_write, mem_write, mem_req,
               illegal_instr, mem_err, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  imm_src, alu_src_a, alu_src_b, result_src, adr_src, alu_control,
               ir_write, pc_write, reg_write, mem_write, mem_req,
               illegal_instr, mem_err, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU control decode: fixed add/sub for address and branch work, funct3-driven for ALU ops.
module multicycle_ctrl_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can subtract; addi ignores IR[30].
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready handshake and an optional wait timeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [1:0]       alu_op;
    logic [2:0]       alu_ctl;
    logic             wait_st;
    logic             timeout;
    logic [CNT_W-1:0] wait_cnt;

    assign wait_st = is_wait_state(state);
    assign timeout = (MEM_TIMEOUT > 0) && rst_n && wait_st && !bus.mem_ready &&
                     (wait_cnt == CNT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Counts consecutive unacknowledged cycles; cleared by ack, timeout or leaving a wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((MEM_TIMEOUT > 0) && wait_st && !bus.mem_ready && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
        if (timeout) state_next = S_FETCH;
    end

    // Gating on rst_n makes every strobe drop the moment reset asserts, mid-access included.
    always_comb begin
        bus.imm_src       = IMM_I;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.result_src    = RES_ALUOUT;
        bus.adr_src       = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_req       = 1'b0;
        bus.illegal_instr = 1'b0;
        alu_op            = ALUOP_ADD;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write   = 1'b1;
                        bus.pc_write   = 1'b1;
                        bus.alu_src_b  = SRCB_FOUR;
                        bus.result_src = RES_ALURES;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_IMM;
                    bus.imm_src   = IMM_B;
                end
                S_MEMADR: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.imm_src   = bus.opcode[5] ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    bus.result_src = RES_MEMDATA;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.adr_src   = 1'b1;
                end
                S_EXECR: begin
                    bus.alu_src_a = SRCA_RS1;
                    alu_op        = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_src_b = SRCB_IMM;
                    alu_op        = ALUOP_FUNCT;
                end
                S_ALUWB:  bus.reg_write = 1'b1;
                S_JAL: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.pc_write  = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.imm_src   = IMM_B;
                    alu_op        = ALUOP_SUB;
                    bus.pc_write  = bus.zero ^ bus.funct3[0];
                end
                S_ILLEGAL: bus.illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

    multicycle_ctrl_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.opcode[5]),
        .alu_control (alu_ctl)
    );

    assign bus.alu_control = alu_ctl;
    assign bus.mem_err     = timeout;
    assign bus.state_dbg   = state;

endmodule
